cp_insert_ctrl: RTL and testbench

Controller that sequences a two-bank symbol RAM for cyclic-prefix insertion on the TX path, between the IFFT output and the DAC/output interface. It accepts NFFT IFFT samples per symbol into alternating banks, then reads each full bank out as LCP prefix samples followed by NFFT body samples at a paced output rate. It issues RAM addresses and enables only; sample data flows RAM -> downstream directly. It also generates framing flags and underrun status.

---
 rtl/cp_pkg.sv | 19 +
 rtl/cp_bank_flags.sv | 36 +++
 rtl/cp_insert_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_cp_insert_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// rtl/cp_pkg.sv - shared parameters, reader states and bank address helper for cp_insert_ctrl
package cp_pkg;

  localparam int NFFT_D = 48;
  localparam int LCP_D  = 16;
  localparam int AW_D   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    BODY = 2'd2
  } rd_state_t;

  // Pack {bank, addr} into the low aw+1 bits; caller casts to its own width
  function automatic logic [31:0] bank_addr(input logic bank, input logic [31:0] addr, input int aw);
    return (32'(bank) << aw) | addr;
  endfunction

endpackage

// File: rtl/cp_bank_flags.sv
// rtl/cp_bank_flags.sv - full flags of the two symbol banks with writer set and reader clear
module cp_bank_flags (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic set_en,
  input  logic set_bank,
  input  logic clr_en,
  input  logic clr_bank,
  input  logic wr_bank,
  input  logic rd_bank,
  output logic wr_rdy,
  output logic rd_avail,
  output logic oth_avail
);

  logic [1:0] full;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;

  assign set_mask = set_en ? (set_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask = clr_en ? (clr_bank ? 2'b10 : 2'b01) : 2'b00;

  // Writer fills and reader drains opposite banks, so a set and a clear in one cycle both land
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      full <= 2'b00;
    end else begin
      full <= (full & ~clr_mask) | set_mask;
    end
  end

  assign wr_rdy    = ~full[wr_bank];
  assign rd_avail  = full[rd_bank];
  assign oth_avail = full[~rd_bank];

endmodule

// File: rtl/cp_insert_ctrl.sv
// rtl/cp_insert_ctrl.sv - two-bank cyclic-prefix insertion sequencer; CP_INSERT_RUNTIME_LCP_EN adds CP_LEN_I
module cp_insert_ctrl
  import cp_pkg::*;
#(
  parameter int NFFT = NFFT_D,
  parameter int LCP  = LCP_D,
  parameter int AW   = AW_D
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          ACK_I,
  output logic          RDY_O,
  output logic          WE_O,
  output logic [AW:0]   WA_O,
  input  logic          TICK_I,
`ifdef CP_INSERT_RUNTIME_LCP_EN
  input  logic [AW:0]   CP_LEN_I,
`endif
  output logic          RE_O,
  output logic [AW:0]   RA_O,
  output logic          VALID_O,
  output logic          SOF_O,
  output logic          EOF_O,
  output logic          UNDERRUN_O,
  output logic [15:0]   SYM_CNT_O
);

  localparam logic [AW:0] NFFT_W = (AW+1)'(NFFT);
  localparam logic [AW:0] LAST_W = (AW+1)'(NFFT - 1);
  localparam logic [AW:0] ONE_W  = (AW+1)'(1);

  logic          wr_bank;
  logic [AW-1:0] wr_ptr;
  logic          set_en;
  logic          rd_bank;
  logic          rd_avail;
  logic          oth_avail;
  rd_state_t     state, state_n;
  logic [AW:0]   cnt, cnt_n;
  logic [AW:0]   rd_addr;
  logic [AW:0]   ra_n;
  logic          re_n, sof_n, eof_n, und_n, sym_done;
  logic          sof_q, eof_q;
  logic [AW:0]   lcp_cur, lcp_start;

  cp_bank_flags u_flags (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .set_en    (set_en),
    .set_bank  (wr_bank),
    .clr_en    (sym_done),
    .clr_bank  (rd_bank),
    .wr_bank   (wr_bank),
    .rd_bank   (rd_bank),
    .wr_rdy    (RDY_O),
    .rd_avail  (rd_avail),
    .oth_avail (oth_avail)
  );

  assign WE_O   = ACK_I & RDY_O;
  assign set_en = WE_O && ({1'b0, wr_ptr} == LAST_W);
  assign WA_O   = (AW+1)'(bank_addr(wr_bank, 32'(wr_ptr), AW));
  assign ra_n   = (AW+1)'(bank_addr(rd_bank, 32'(rd_addr), AW));

`ifdef CP_INSERT_RUNTIME_LCP_EN
  assign lcp_start = (CP_LEN_I > NFFT_W) ? NFFT_W : CP_LEN_I;

  // Capture the prefix length as each symbol starts so it stays fixed for that symbol
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      lcp_cur <= (AW+1)'(LCP);
    end else if (TICK_I && (((state == IDLE) && rd_avail) ||
                            ((state == BODY) && (cnt == LAST_W) && oth_avail))) begin
      lcp_cur <= lcp_start;
    end
  end
`else
  assign lcp_start = (AW+1)'(LCP);
  assign lcp_cur   = (AW+1)'(LCP);
`endif

  // Writer pointer walks a bank, then hands it to the reader and moves to the other bank
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
    end else if (WE_O) begin
      if (set_en) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  // Reader next state: one read per tick, prefix tail then full body; chain symbols when the next bank is ready
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rd_addr  = '0;
    re_n     = 1'b0;
    sof_n    = 1'b0;
    eof_n    = 1'b0;
    und_n    = 1'b0;
    sym_done = 1'b0;
    if (TICK_I) begin
      case (state)
        IDLE: begin
          if (rd_avail) begin
            re_n  = 1'b1;
            sof_n = 1'b1;
            if (lcp_start == '0) begin
              rd_addr = '0;
              cnt_n   = ONE_W;
              state_n = BODY;
            end else begin
              rd_addr = NFFT_W - lcp_start;
              if (lcp_start == ONE_W) begin
                cnt_n   = '0;
                state_n = BODY;
              end else begin
                cnt_n   = ONE_W;
                state_n = CP;
              end
            end
          end else begin
            und_n = 1'b1;
          end
        end
        CP: begin
          re_n    = 1'b1;
          sof_n   = (cnt == '0);
          rd_addr = NFFT_W - lcp_cur + cnt;
          if (cnt + ONE_W == lcp_cur) begin
            cnt_n   = '0;
            state_n = BODY;
          end else begin
            cnt_n = cnt + ONE_W;
          end
        end
        BODY: begin
          re_n    = 1'b1;
          sof_n   = (cnt == '0) && (lcp_cur == '0);
          rd_addr = cnt;
          if (cnt == LAST_W) begin
            eof_n    = 1'b1;
            sym_done = 1'b1;
            cnt_n    = '0;
            if (oth_avail) begin
              state_n = (lcp_start == '0) ? BODY : CP;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + ONE_W;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Reader registers: read strobe/address, framing pipeline aligned to 1-cycle RAM latency, counters
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_bank    <= 1'b0;
      RE_O       <= 1'b0;
      RA_O       <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      VALID_O    <= 1'b0;
      SOF_O      <= 1'b0;
      EOF_O      <= 1'b0;
      UNDERRUN_O <= 1'b0;
      SYM_CNT_O  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      RE_O       <= re_n;
      if (re_n) begin
        RA_O <= ra_n;
      end
      sof_q      <= sof_n;
      eof_q      <= eof_n;
      VALID_O    <= RE_O;
      SOF_O      <= sof_q;
      EOF_O      <= eof_q;
      UNDERRUN_O <= und_n;
      if (sym_done) begin
        rd_bank   <= ~rd_bank;
        SYM_CNT_O <= SYM_CNT_O + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cp_insert_ctrl.sv
// tb/tb_cp_insert_ctrl.sv - self-checking bench for cp_insert_ctrl against a symbol-level model
module tb_cp_insert_ctrl;

  localparam int N  = 48;
  localparam int L  = 16;
  localparam int AW = 6;

  logic          CLK_I  = 1'b0;
  logic          RST_I  = 1'b1;
  logic          ACK_I  = 1'b0;
  logic          TICK_I = 1'b0;
  logic          RDY_O, WE_O, RE_O, VALID_O, SOF_O, EOF_O, UNDERRUN_O;
  logic [AW:0]   WA_O, RA_O;
  logic [15:0]   SYM_CNT_O;

  int n_vec = 0;
  int n_bad = 0;

  cp_insert_ctrl #(.NFFT(N), .LCP(L), .AW(AW)) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .ACK_I      (ACK_I),
    .RDY_O      (RDY_O),
    .WE_O       (WE_O),
    .WA_O       (WA_O),
    .TICK_I     (TICK_I),
`ifdef CP_INSERT_RUNTIME_LCP_EN
    .CP_LEN_I   (7'd16),
`endif
    .RE_O       (RE_O),
    .RA_O       (RA_O),
    .VALID_O    (VALID_O),
    .SOF_O      (SOF_O),
    .EOF_O      (EOF_O),
    .UNDERRUN_O (UNDERRUN_O),
    .SYM_CNT_O  (SYM_CNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Symbol-level model: queue of full banks, position inside the LCP+N read sequence
  int          fullq[$];
  int          m_wbank = 0, m_wptr = 0, m_pos = 0, m_acc = 0;
  logic [15:0] m_sym = '0;
  logic        e_re = 0, e_sofq = 0, e_eofq = 0, e_valid = 0, e_sof = 0, e_eof = 0, e_und = 0;
  int          e_ra = 0;

  // Observed-behaviour counters used by the literal checks
  int o_valid, o_sof, o_eof, o_und, o_re, o_rdylow, run, max_run, first_ra;

  always @(negedge CLK_I) begin
    logic rdy;
    int   addr;
    if (VALID_O) begin o_valid++; run++; if (run > max_run) max_run = run; end else run = 0;
    if (SOF_O) o_sof++;
    if (EOF_O) o_eof++;
    if (UNDERRUN_O) o_und++;
    if (!RDY_O) o_rdylow++;
    if (RE_O) begin o_re++; if (first_ra < 0) first_ra = int'(RA_O); end
    if (RST_I) begin
      fullq.delete();
      m_wbank = 0; m_wptr = 0; m_pos = 0; m_sym = '0;
      e_re = 0; e_sofq = 0; e_eofq = 0; e_valid = 0; e_sof = 0; e_eof = 0; e_und = 0; e_ra = 0;
      chk("rst_re", RE_O, 0);
      chk("rst_ra", RA_O, 0);
      chk("rst_valid", VALID_O, 0);
      chk("rst_sof", SOF_O, 0);
      chk("rst_eof", EOF_O, 0);
      chk("rst_und", UNDERRUN_O, 0);
      chk("rst_sym", SYM_CNT_O, 0);
      chk("rst_rdy", RDY_O, 1);
      chk("rst_wa", WA_O, 0);
    end else begin
      rdy = (fullq.size() < 2);
      chk("rdy", RDY_O, rdy);
      chk("we", WE_O, ACK_I & rdy);
      chk("wa", WA_O, m_wbank * (1 << AW) + m_wptr);
      chk("re", RE_O, e_re);
      if (e_re) chk("ra", RA_O, e_ra);
      chk("valid", VALID_O, e_valid);
      chk("sof", SOF_O, e_sof);
      chk("eof", EOF_O, e_eof);
      chk("underrun", UNDERRUN_O, e_und);
      chk("sym_cnt", SYM_CNT_O, m_sym);
      e_valid = e_re; e_sof = e_sofq; e_eof = e_eofq;
      e_re = 0; e_sofq = 0; e_eofq = 0; e_und = 0;
      if (TICK_I) begin
        if (fullq.size() > 0) begin
          addr   = (m_pos < L) ? (N - L + m_pos) : (m_pos - L);
          e_re   = 1;
          e_ra   = fullq[0] * (1 << AW) + addr;
          e_sofq = (m_pos == 0);
          e_eofq = (m_pos == L + N - 1);
          m_pos++;
          if (m_pos == L + N) begin
            m_pos = 0;
            void'(fullq.pop_front());
            m_sym++;
          end
        end else begin
          e_und = 1;
        end
      end
      if (ACK_I && rdy) begin
        m_acc++;
        m_wptr++;
        if (m_wptr == N) begin
          m_wptr = 0;
          fullq.push_back(m_wbank);
          m_wbank ^= 1;
        end
      end
    end
  end

  task automatic cyc(input logic a, input logic t);
    ACK_I = a; TICK_I = t;
    @(posedge CLK_I); #1;
  endtask

  task automatic do_reset();
    RST_I = 1'b1; ACK_I = 1'b0; TICK_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    #1 RST_I = 1'b0;
  endtask

  task automatic clear_obs();
    o_valid = 0; o_sof = 0; o_eof = 0; o_und = 0; o_re = 0; o_rdylow = 0;
    run = 0; max_run = 0; first_ra = -1;
  endtask

  initial begin
    int start;
    clear_obs();
    do_reset();

    // single symbol, tick every cycle
    clear_obs();
    repeat (N) cyc(1, 0);
    repeat (70) cyc(0, 1);
    cyc(0, 0);
    chk("t1_valid_cnt", o_valid, 64);
    chk("t1_sof_cnt", o_sof, 1);
    chk("t1_eof_cnt", o_eof, 1);
    chk("t1_first_ra", first_ra, 32);
    chk("t1_sym", SYM_CNT_O, 1);
    chk("t1_und_cnt", o_und, 6);

    // three symbols back to back, continuous ticks
    do_reset();
    clear_obs();
    start = m_acc;
    repeat (N) cyc(1, 0);
    for (int k = 0; k < 260; k++) cyc((m_acc - start) < 3 * N, 1);
    cyc(0, 0);
    chk("t2_max_run", max_run, 192);
    chk("t2_valid_cnt", o_valid, 192);
    chk("t2_sof_cnt", o_sof, 3);
    chk("t2_sym", SYM_CNT_O, 3);
    chk("t2_rdy_low_cycles", o_rdylow, 32);

    // tick every fourth cycle
    do_reset();
    clear_obs();
    repeat (N) cyc(1, 0);
    for (int k = 0; k < 64 * 4 + 8; k++) cyc(0, (k % 4) == 0);
    chk("t3_re_cnt", o_re, 64);
    chk("t3_valid_cnt", o_valid, 64);
    chk("t3_max_run", max_run, 1);
    chk("t3_eof_cnt", o_eof, 1);
    chk("t3_sym", SYM_CNT_O, 1);

    // ticks with no data
    do_reset();
    clear_obs();
    for (int k = 0; k < 20; k++) cyc(0, (k % 2) == 0);
    cyc(0, 0);
    chk("t4_und_cnt", o_und, 10);
    chk("t4_re_cnt", o_re, 0);
    chk("t4_sym", SYM_CNT_O, 0);

    // writer blocked with both banks full, released at last body read
    do_reset();
    clear_obs();
    start = m_acc;
    repeat (2 * N) cyc(1, 0);
    repeat (20) cyc(1, 0);
    ACK_I = 1'b1; TICK_I = 1'b0;
    @(negedge CLK_I); #1;
    chk("t5_blocked_rdy", RDY_O, 0);
    chk("t5_blocked_we", WE_O, 0);
    chk("t5_blocked_wa", WA_O, 0);
    @(posedge CLK_I); #1;
    repeat (63) cyc(1, 1);
    ACK_I = 1'b1; TICK_I = 1'b1;
    @(negedge CLK_I); #1;
    chk("t5_rdy_at_last_read", RDY_O, 0);
    @(posedge CLK_I); #1;
    ACK_I = 1'b1; TICK_I = 1'b1;
    @(negedge CLK_I); #1;
    chk("t5_rdy_after_release", RDY_O, 1);
    chk("t5_we_after_release", WE_O, 1);
    @(posedge CLK_I); #1;
    for (int k = 0; k < 200; k++) cyc((m_acc - start) < 3 * N, 1);
    cyc(0, 0);
    chk("t5_sym", SYM_CNT_O, 3);
    chk("t5_sof_cnt", o_sof, 3);

    // reset at body sample 20, then a clean symbol
    do_reset();
    clear_obs();
    repeat (N) cyc(1, 0);
    repeat (L + 20) cyc(0, 1);
    RST_I = 1'b1;
    #1;
    chk("t6_rst_re", RE_O, 0);
    chk("t6_rst_valid", VALID_O, 0);
    chk("t6_rst_ra", RA_O, 0);
    chk("t6_rst_rdy", RDY_O, 1);
    chk("t6_rst_sym", SYM_CNT_O, 0);
    do_reset();
    clear_obs();
    repeat (N) cyc(1, 0);
    repeat (70) cyc(0, 1);
    cyc(0, 0);
    chk("t6_valid_cnt", o_valid, 64);
    chk("t6_sof_cnt", o_sof, 1);
    chk("t6_eof_cnt", o_eof, 1);
    chk("t6_first_ra", first_ra, 32);
    chk("t6_sym", SYM_CNT_O, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
